// File: rtl/warp_controller.sv
// Per-warp sequencer: walks one instruction at a time through fetch, decode,
// operand request, memory wait, execute and pc update until a halt retires the warp.
package warp_controller_pkg;
    localparam int INSTR_ADDR_WIDTH = 8;

    typedef logic [INSTR_ADDR_WIDTH-1:0] instruction_memory_address_t;

    typedef enum logic [2:0] {
        WARP_IDLE    = 3'd0,
        WARP_FETCH   = 3'd1,
        WARP_DECODE  = 3'd2,
        WARP_REQUEST = 3'd3,
        WARP_WAIT    = 3'd4,
        WARP_EXECUTE = 3'd5,
        WARP_UPDATE  = 3'd6,
        WARP_DONE    = 3'd7
    } warp_state_t;
endpackage

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module warp_controller
    import warp_controller_pkg::*;
#(
    parameter int                          DATA_WIDTH = `DATA_WIDTH,
    parameter instruction_memory_address_t START_PC   = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic                        start,
    output logic                        fetch_valid,
    input  logic                        fetch_ready,
    input  logic                        decoded_mem_access,
    input  logic                        decoded_halt,
    input  logic                        decoded_pc_mux,
    input  logic [DATA_WIDTH-1:0]       alu_out,
    output logic                        lsu_request,
    input  logic                        lsu_done,
    output warp_state_t                 warp_state,
    output instruction_memory_address_t pc,
    output logic                        done
);

    localparam int PC_W = INSTR_ADDR_WIDTH;

    warp_state_t                 state_reg, state_next;
    instruction_memory_address_t pc_reg, pc_next;
    instruction_memory_address_t alu_pc;

    // Branch targets keep only the low pc bits; narrower ALUs are zero-extended.
    generate
        if (DATA_WIDTH >= PC_W) begin : g_alu_trunc
            assign alu_pc = alu_out[PC_W-1:0];
            if (DATA_WIDTH > PC_W) begin : g_alu_hi
                logic unused_alu_hi;
                assign unused_alu_hi = ^alu_out[DATA_WIDTH-1:PC_W];
            end
        end else begin : g_alu_ext
            assign alu_pc = {{(PC_W-DATA_WIDTH){1'b0}}, alu_out};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= WARP_IDLE;
            pc_reg    <= START_PC;
        end else if (enable) begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        case (state_reg)
            WARP_IDLE:    if (start) state_next = WARP_FETCH;
            WARP_FETCH:   if (fetch_ready) state_next = WARP_DECODE;
            WARP_DECODE:  state_next = WARP_REQUEST;
            WARP_REQUEST: state_next = WARP_WAIT;
            WARP_WAIT: begin
                if (!decoded_mem_access || lsu_done) state_next = WARP_EXECUTE;
            end
            WARP_EXECUTE: state_next = WARP_UPDATE;
            WARP_UPDATE: begin
                if (decoded_halt) begin
                    state_next = WARP_DONE;
                end else begin
                    pc_next    = decoded_pc_mux ? alu_pc : pc_reg + PC_W'(1);
                    state_next = WARP_FETCH;
                end
            end
            WARP_DONE:    state_next = WARP_DONE;
            default:      state_next = WARP_IDLE;
        endcase
    end

    // Requests drop the moment the warp is disabled so the memories see no stale strobe.
    always_comb begin
        fetch_valid = 1'b0;
        lsu_request = 1'b0;
        done        = 1'b0;
        case (state_reg)
            WARP_FETCH: fetch_valid = enable;
            WARP_WAIT:  lsu_request = enable && decoded_mem_access && !lsu_done;
            WARP_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign warp_state = state_reg;
    assign pc         = pc_reg;

endmodule

// File: tb/tb_warp_controller.sv
// Directed bench: stimulus queues the expected per-cycle outputs, a negedge
// monitor pops and compares them against the DUT.
module tb_warp_controller;
    import warp_controller_pkg::*;

    logic                        clk;
    logic                        reset;
    logic                        enable;
    logic                        start;
    logic                        fetch_valid;
    logic                        fetch_ready;
    logic                        decoded_mem_access;
    logic                        decoded_halt;
    logic                        decoded_pc_mux;
    logic [31:0]                 alu_out;
    logic                        lsu_request;
    logic                        lsu_done;
    warp_state_t                 warp_state;
    instruction_memory_address_t pc;
    logic                        done;

    typedef struct {
        warp_state_t st;
        logic [7:0]  pc;
        logic        fv;
        logic        lr;
        logic        dn;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    warp_controller #(.DATA_WIDTH(32), .START_PC(8'h00)) dut (
        .clk                (clk),
        .reset              (reset),
        .enable             (enable),
        .start              (start),
        .fetch_valid        (fetch_valid),
        .fetch_ready        (fetch_ready),
        .decoded_mem_access (decoded_mem_access),
        .decoded_halt       (decoded_halt),
        .decoded_pc_mux     (decoded_pc_mux),
        .alu_out            (alu_out),
        .lsu_request        (lsu_request),
        .lsu_done           (lsu_done),
        .warp_state         (warp_state),
        .pc                 (pc),
        .done               (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Monitor: one comparison per queued cycle, one line per fetch/LSU handshake.
    always @(negedge clk) begin
        if (fetch_valid && fetch_ready)
            $display("fetch  pc=%02h", pc);
        if (warp_state == WARP_WAIT && decoded_mem_access && lsu_done && enable)
            $display("lsu    pc=%02h complete", pc);
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (warp_state !== e.st || pc !== e.pc || fetch_valid !== e.fv ||
                lsu_request !== e.lr || done !== e.dn) begin
                errors++;
                $display("FAIL cycle_%0d: got state=%0d pc=%02h fv=%b lr=%b done=%b, want state=%0d pc=%02h fv=%b lr=%b done=%b",
                         checks, warp_state, pc, fetch_valid, lsu_request, done,
                         e.st, e.pc, e.fv, e.lr, e.dn);
            end
        end
    end

    task automatic cyc(input warp_state_t st, input logic [7:0] p,
                       input logic fv, input logic lr, input logic dn);
        exp_t e;
        e.st = st; e.pc = p; e.fv = fv; e.lr = lr; e.dn = dn;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // One non-memory instruction with immediate fetch_ready.
    task automatic plain(input logic [7:0] p, input logic mux,
                         input logic [31:0] tgt, input logic halt);
        fetch_ready = 1'b1;
        cyc(WARP_FETCH, p, 1, 0, 0);
        fetch_ready = 1'b0;
        cyc(WARP_DECODE, p, 0, 0, 0);
        cyc(WARP_REQUEST, p, 0, 0, 0);
        cyc(WARP_WAIT, p, 0, 0, 0);
        cyc(WARP_EXECUTE, p, 0, 0, 0);
        decoded_pc_mux = mux;
        alu_out        = tgt;
        decoded_halt   = halt;
        cyc(WARP_UPDATE, p, 0, 0, 0);
        decoded_pc_mux = 1'b0;
        alu_out        = '0;
        decoded_halt   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0; fetch_ready = 1'b0;
        decoded_mem_access = 1'b0; decoded_halt = 1'b0; decoded_pc_mux = 1'b0;
        alu_out = '0; lsu_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        cyc(WARP_IDLE, 8'h00, 0, 0, 0);
        reset = 1'b0;
        cyc(WARP_IDLE, 8'h00, 0, 0, 0);
        start = 1'b1;
        cyc(WARP_IDLE, 8'h00, 0, 0, 0);
        start = 1'b0;

        // Straight-line code: 6 cycles per instruction, pc 0,1,2,3
        plain(8'h00, 0, 0, 0);
        plain(8'h01, 0, 0, 0);
        plain(8'h02, 0, 0, 0);

        // Load at pc 3: LSU answers 4 cycles into WAIT
        fetch_ready = 1'b1;
        cyc(WARP_FETCH, 8'h03, 1, 0, 0);
        fetch_ready = 1'b0;
        decoded_mem_access = 1'b1;
        cyc(WARP_DECODE, 8'h03, 0, 0, 0);
        cyc(WARP_REQUEST, 8'h03, 0, 0, 0);
        repeat (4) cyc(WARP_WAIT, 8'h03, 0, 1, 0);
        lsu_done = 1'b1;
        cyc(WARP_WAIT, 8'h03, 0, 0, 0);
        lsu_done = 1'b0;
        decoded_mem_access = 1'b0;
        cyc(WARP_EXECUTE, 8'h03, 0, 0, 0);
        cyc(WARP_UPDATE, 8'h03, 0, 0, 0);

        // pc 4: fetch stall, stray start/lsu_done, enable dropped in WAIT and UPDATE
        lsu_done = 1'b1;
        start    = 1'b1;
        repeat (3) cyc(WARP_FETCH, 8'h04, 1, 0, 0);
        lsu_done = 1'b0;
        start    = 1'b0;
        fetch_ready = 1'b1;
        cyc(WARP_FETCH, 8'h04, 1, 0, 0);
        fetch_ready = 1'b0;
        cyc(WARP_DECODE, 8'h04, 0, 0, 0);
        cyc(WARP_REQUEST, 8'h04, 0, 0, 0);
        decoded_mem_access = 1'b1;
        cyc(WARP_WAIT, 8'h04, 0, 1, 0);
        enable = 1'b0;
        repeat (2) cyc(WARP_WAIT, 8'h04, 0, 0, 0);
        enable = 1'b1;
        lsu_done = 1'b1;
        cyc(WARP_WAIT, 8'h04, 0, 0, 0);
        lsu_done = 1'b0;
        decoded_mem_access = 1'b0;
        cyc(WARP_EXECUTE, 8'h04, 0, 0, 0);
        enable = 1'b0;
        decoded_pc_mux = 1'b1;
        alu_out = 32'h0000_0099;
        cyc(WARP_UPDATE, 8'h04, 0, 0, 0);
        enable = 1'b1;
        decoded_pc_mux = 1'b0;
        alu_out = '0;
        cyc(WARP_UPDATE, 8'h04, 0, 0, 0);

        // Branches: truncation, pc+1 wrap, in-range target, then halt at pc 5
        plain(8'h05, 1, 32'h0000_01FF, 0);
        plain(8'hFF, 0, 32'h0000_0000, 0);
        plain(8'h00, 1, 32'h0000_0040, 0);
        plain(8'h40, 1, 32'h0000_0005, 0);
        plain(8'h05, 0, 32'h0000_0000, 1);

        cyc(WARP_DONE, 8'h05, 0, 0, 1);
        start = 1'b1;
        cyc(WARP_DONE, 8'h05, 0, 0, 1);
        start = 1'b0;
        cyc(WARP_DONE, 8'h05, 0, 0, 1);

        // Reset out of DONE, relaunch, then reset while a load is pending
        reset = 1'b1;
        cyc(WARP_DONE, 8'h05, 0, 0, 1);
        reset = 1'b0;
        cyc(WARP_IDLE, 8'h00, 0, 0, 0);
        start = 1'b1;
        cyc(WARP_IDLE, 8'h00, 0, 0, 0);
        start = 1'b0;
        fetch_ready = 1'b1;
        cyc(WARP_FETCH, 8'h00, 1, 0, 0);
        fetch_ready = 1'b0;
        cyc(WARP_DECODE, 8'h00, 0, 0, 0);
        cyc(WARP_REQUEST, 8'h00, 0, 0, 0);
        decoded_mem_access = 1'b1;
        repeat (2) cyc(WARP_WAIT, 8'h00, 0, 1, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) cyc(WARP_IDLE, 8'h00, 0, 0, 0);
        decoded_mem_access = 1'b0;

        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending entries, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
